// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one partial product per clock, start/done
// handshake, unsigned or two's-complement operands, full 2*WIDTH-bit product.
module seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_r, state_s;
    logic [PW-1:0]   mcand_r, mcand_s;
    logic [WIDTH-1:0] mplier_r, mplier_s;
    logic [PW-1:0]   acc_r, acc_s;
    logic [PW-1:0]   sum_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic            neg_r, neg_s;
    logic            busy_r, busy_s;
    logic            done_r, done_s;
    logic [PW-1:0]   p_r, p_s;

    // Unsigned magnitude of an operand; -2^(WIDTH-1) maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             is_signed);
        if (is_signed && v[WIDTH-1]) begin
            magnitude = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            magnitude = v;
        end
    endfunction

    function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] v,
                                                 input logic          neg);
        if (neg) begin
            apply_sign = ~v + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            apply_sign = v;
        end
    endfunction

    // Next-state, datapath and output logic.
    always_comb begin
        state_s  = state_r;
        mcand_s  = mcand_r;
        mplier_s = mplier_r;
        acc_s    = acc_r;
        cnt_s    = cnt_r;
        neg_s    = neg_r;
        busy_s   = 1'b0;
        done_s   = 1'b0;
        p_s      = p_r;
        sum_s    = acc_r + (mplier_r[0] ? mcand_r : {PW{1'b0}});
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s  = RUN;
                    mcand_s  = {{WIDTH{1'b0}}, magnitude(a, signed_mode)};
                    mplier_s = magnitude(b, signed_mode);
                    neg_s    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_s    = {PW{1'b0}};
                    cnt_s    = {CW{1'b0}};
                    busy_s   = 1'b1;
                end else begin
                    busy_s   = 1'b0;
                end
            end
            RUN: begin
                acc_s    = sum_s;
                mcand_s  = {mcand_r[PW-2:0], 1'b0};
                mplier_s = {1'b0, mplier_r[WIDTH-1:1]};
                cnt_s    = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                // The last partial product is folded straight into p.
                if (cnt_r == CW'(WIDTH - 1)) begin
                    state_s = IDLE;
                    p_s     = apply_sign(sum_s, neg_r);
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                end else begin
                    busy_s  = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            mcand_r  <= {PW{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            neg_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            p_r      <= {PW{1'b0}};
        end else begin
            state_r  <= state_s;
            mcand_r  <= mcand_s;
            mplier_r <= mplier_s;
            acc_r    <= acc_s;
            cnt_r    <= cnt_s;
            neg_r    <= neg_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            p_r      <= p_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign p    = p_r;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier at WIDTH=4 and WIDTH=5.
module tb_seq_multiplier;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start4 = 1'b0, sm4 = 1'b0, busy4, done4;
    logic [3:0] a4 = 4'd0, b4 = 4'd0;
    logic [7:0] p4;

    logic       start5 = 1'b0, sm5 = 1'b0, busy5, done5;
    logic [4:0] a5 = 5'd0, b5 = 5'd0;
    logic [9:0] p5;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .p(p4)
    );

    seq_multiplier #(.WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .signed_mode(sm5),
        .a(a5), .b(b5), .busy(busy5), .done(done5), .p(p5)
    );

    // Launch one WIDTH=4 multiply; report product, edges from start to done,
    // and whether done was a clean single-cycle pulse with busy low.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic sm,
                        output logic [7:0] p, output int lat, output logic pulse_ok);
        @(negedge clk);
        start4 = 1'b1; a4 = a; b4 = b; sm4 = sm;
        @(posedge clk); #1;
        start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); sm4 = ~sm;
        lat = 0;
        while (!done4 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        p = p4;
        pulse_ok = done4 && !busy4;
        @(posedge clk); #1;
        pulse_ok = pulse_ok && !done4;
    endtask

    task automatic run5(input logic [4:0] a, input logic [4:0] b, input logic sm,
                        output logic [9:0] p, output int lat);
        @(negedge clk);
        start5 = 1'b1; a5 = a; b5 = b; sm5 = sm;
        @(posedge clk); #1;
        start5 = 1'b0; a5 = 5'($urandom); b5 = 5'($urandom);
        lat = 0;
        while (!done5 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        p = p5;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({busy4, done4, p4} !== 10'd0) begin
            errors++;
            $display("FAIL reset_w4: busy=%b done=%b p=%h, need 0 0 00", busy4, done4, p4);
        end
        vectors++;
        if ({busy5, done5, p5} !== 12'd0) begin
            errors++;
            $display("FAIL reset_w5: busy=%b done=%b p=%h, need 0 0 000", busy5, done5, p5);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_unsigned_w4();
        logic [7:0] p;
        int lat;
        logic ok;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                run4(4'(i), 4'(j), 1'b0, p, lat, ok);
                vectors++;
                if (p !== 8'(i * j)) begin
                    errors++;
                    $display("FAIL uns4 %0d*%0d: p=%0d need %0d", i, j, p, i * j);
                end
                vectors++;
                if (lat != 4 || !ok) begin
                    errors++;
                    $display("FAIL uns4_timing %0d*%0d: latency=%0d pulse_ok=%b need 4 1", i, j, lat, ok);
                end
            end
        end
    endtask

    task automatic test_signed_w4();
        logic [3:0] ta [5] = '{4'h8, 4'h8, 4'hF, 4'h0, 4'h7};
        logic [3:0] tb [5] = '{4'h8, 4'h7, 4'h1, 4'h8, 4'h7};
        logic [7:0] te [5] = '{8'h40, 8'hC8, 8'hFF, 8'h00, 8'h31};
        logic [7:0] p;
        logic [3:0] av, bv;
        int lat, sa, sb;
        logic ok;
        for (int k = 0; k < 5; k++) begin
            run4(ta[k], tb[k], 1'b1, p, lat, ok);
            vectors++;
            if (p !== te[k] || lat != 4 || !ok) begin
                errors++;
                $display("FAIL sgn4_corner %h*%h: p=%h lat=%0d ok=%b need %h 4 1",
                         ta[k], tb[k], p, lat, ok, te[k]);
            end
        end
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                av = 4'(i); bv = 4'(j);
                sa = $signed(av); sb = $signed(bv);
                run4(av, bv, 1'b1, p, lat, ok);
                vectors++;
                if (p !== 8'(sa * sb) || lat != 4 || !ok) begin
                    errors++;
                    $display("FAIL sgn4 %0d*%0d: p=%h need %h lat=%0d", sa, sb, p, 8'(sa * sb), lat);
                end
            end
        end
    endtask

    task automatic test_w5();
        logic [9:0] p;
        logic [4:0] av, bv;
        int lat, sa, sb;
        run5(5'd31, 5'd31, 1'b0, p, lat);
        vectors++;
        if (p !== 10'h3C1 || lat != 5) begin
            errors++;
            $display("FAIL w5_31x31: p=%h lat=%0d need 3c1 5", p, lat);
        end
        run5(5'h10, 5'h10, 1'b1, p, lat);
        vectors++;
        if (p !== 10'h100 || lat != 5) begin
            errors++;
            $display("FAIL w5_m16xm16: p=%h lat=%0d need 100 5", p, lat);
        end
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 32; i++) begin
                for (int j = 0; j < 32; j++) begin
                    av = 5'(i); bv = 5'(j);
                    sa = (m == 1) ? int'($signed(av)) : i;
                    sb = (m == 1) ? int'($signed(bv)) : j;
                    run5(av, bv, 1'(m), p, lat);
                    vectors++;
                    if (p !== 10'(sa * sb) || lat != 5) begin
                        errors++;
                        $display("FAIL w5 mode%0d %0d*%0d: p=%h need %h lat=%0d",
                                 m, sa, sb, p, 10'(sa * sb), lat);
                    end
                end
            end
        end
    endtask

    task automatic test_busy_ignore();
        int ndone = 0, first = 0;
        @(negedge clk);
        start4 = 1'b1; a4 = 4'd3; b4 = 4'd5; sm4 = 1'b0;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(negedge clk);
        start4 = 1'b1; a4 = 4'd15; b4 = 4'd15; sm4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        for (int cyc = 2; cyc <= 14; cyc++) begin
            @(posedge clk); #1;
            if (done4) begin
                ndone++;
                if (first == 0) first = cyc;
                vectors++;
                if (p4 !== 8'd15) begin
                    errors++;
                    $display("FAIL busy_ignore_p: p=%0d need 15", p4);
                end
            end
        end
        vectors++;
        if (ndone != 1 || first != 4) begin
            errors++;
            $display("FAIL busy_ignore_pulses: count=%0d at=%0d need 1 at 4", ndone, first);
        end
    endtask

    task automatic test_reset_midrun();
        logic [7:0] p;
        int lat, ndone = 0;
        logic ok;
        @(negedge clk);
        start4 = 1'b1; a4 = 4'd9; b4 = 4'd9; sm4 = 1'b0;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy4, done4, p4} !== 10'd0) begin
            errors++;
            $display("FAIL reset_midrun: busy=%b done=%b p=%h need 0 0 00", busy4, done4, p4);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done4 || busy4) ndone++;
        end
        vectors++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL reset_abort: %0d cycles with done/busy, need 0", ndone);
        end
        run4(4'd6, 4'd7, 1'b0, p, lat, ok);
        vectors++;
        if (p !== 8'd42 || lat != 4 || !ok) begin
            errors++;
            $display("FAIL after_reset 6*7: p=%0d lat=%0d need 42 4", p, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] oa [3] = '{4'd2, 4'd15, 4'd9};
        logic [3:0] ob [3] = '{4'd3, 4'd15, 4'd11};
        logic [7:0] oe [3] = '{8'd6, 8'd225, 8'd99};
        int at [3] = '{0, 0, 0};
        int k = 0;
        @(negedge clk);
        start4 = 1'b1; a4 = oa[0]; b4 = ob[0]; sm4 = 1'b0;
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= 30 && k < 3; cyc++) begin
            @(posedge clk); #1;
            if (done4) begin
                at[k] = cyc;
                vectors++;
                if (p4 !== oe[k]) begin
                    errors++;
                    $display("FAIL b2b_p op%0d: p=%0d need %0d", k, p4, oe[k]);
                end
                k++;
                if (k < 3) begin
                    a4 = oa[k]; b4 = ob[k];
                end else begin
                    start4 = 1'b0;
                end
            end
        end
        start4 = 1'b0;
        vectors++;
        if (k != 3 || at[0] != 4 || at[1] != 9 || at[2] != 14) begin
            errors++;
            $display("FAIL b2b_spacing: pulses=%0d at %0d %0d %0d need 3 at 4 9 14",
                     k, at[0], at[1], at[2]);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_w4();
        test_signed_w4();
        test_w5();
        test_busy_ignore();
        test_reset_midrun();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
